// File: rtl/mem_pkg.sv
// Shared types and constants for the single-port memory controller.
// The CPU-side fetch and data paths are both served by one backing memory port.
package mem_pkg;

  localparam int WORD_W          = 16;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC,
    DONE
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Serialises a CPU's data access and instruction fetch onto one backing memory port.
// The data access goes first. err is a sticky flag that records a backing memory that never acknowledges.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch,
  input  logic [AW-1:0]     i_addr,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     d_addr,
  input  logic [WORD_W-1:0] wrt_data,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] rd_data,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  state_t          state;
  logic            req_fetch;
  logic            req_rd;
  logic            req_wr;
  logic [AW-1:0]   req_i_addr;
  logic [CNT_W-1:0] wait_cnt;

  logic        any_req;
  logic        waiting;
  logic [31:0] wait_next;
  logic        timeout_hit;

  assign any_req     = i_fetch | re | we;
  assign ready       = (state == DONE) || ((state == IDLE) && !any_req);
  assign waiting     = ((state == D_ACC) || (state == I_ACC)) && !mem_ack;
  assign wait_next   = 32'(wait_cnt) + 32'd1;
  assign timeout_hit = wait_next >= 32'(TIMEOUT);

  // The data address and write data go straight into the mem_addr and mem_wdata
  // output registers. They stay there for the whole data access.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_fetch  <= 1'b0;
      req_rd     <= 1'b0;
      req_wr     <= 1'b0;
      req_i_addr <= '0;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      instr      <= '0;
      rd_data    <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            req_fetch  <= i_fetch;
            req_rd     <= re;
            req_wr     <= we;
            req_i_addr <= i_addr;
            mem_wdata  <= wrt_data;
            wait_cnt   <= '0;
            mem_req    <= 1'b1;
            if (re || we) begin
              state    <= D_ACC;
              mem_we   <= we;
              mem_addr <= d_addr;
            end else begin
              state    <= I_ACC;
              mem_we   <= 1'b0;
              mem_addr <= i_addr;
            end
          end
        end

        D_ACC: begin
          if (mem_ack) begin
            // A combined read+write acts as a write that also returns the written value.
            if (req_wr) begin
              if (req_rd) rd_data <= mem_wdata;
            end else begin
              rd_data <= mem_rdata;
            end
            mem_we <= 1'b0;
            if (req_fetch) begin
              state    <= I_ACC;
              mem_addr <= req_i_addr;
              wait_cnt <= '0;
            end else begin
              state   <= DONE;
              mem_req <= 1'b0;
            end
          end
        end

        I_ACC: begin
          if (mem_ack) begin
            instr   <= mem_rdata;
            state   <= DONE;
            mem_req <= 1'b0;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A timeout only raises the flag. The access stays pending until mem_ack arrives.
      if (waiting) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        if (timeout_hit) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised and directed bench for mem_ctrl.
// A queue-of-pending-accesses model predicts every output on each falling edge.
module tb_mem_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fetch, re, we, mem_ack;
  logic [15:0] i_addr, d_addr, wrt_data, mem_rdata;
  logic [15:0] instr, rd_data, mem_addr, mem_wdata;
  logic        ready, mem_req, mem_we, err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mem_ctrl #(.TIMEOUT(TIMEOUT), .AW(16)) dut (
    .clk(clk), .rst(rst), .i_fetch(i_fetch), .i_addr(i_addr), .re(re), .we(we),
    .d_addr(d_addr), .wrt_data(wrt_data), .instr(instr), .rd_data(rd_data),
    .ready(ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic        rd;
    logic [15:0] wdata;
    bit          fetch;
  } acc_t;

  acc_t        q[$];
  acc_t        cur;
  acc_t        nxt;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  int          m_wait = 0;
  logic [15:0] m_instr = '0;
  logic [15:0] m_rd = '0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_done = 0; m_err = 0; m_wait = 0; m_instr = '0; m_rd = '0;
    end else if (q.size() != 0) begin
      if (mem_ack) begin
        cur = q.pop_front();
        if (cur.fetch) m_instr = mem_rdata;
        else if (cur.rd && cur.wr) m_rd = cur.wdata;
        else if (cur.rd) m_rd = mem_rdata;
        m_wait = 0;
        if (q.size() == 0) m_done = 1;
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_err = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (i_fetch || re || we) begin
      m_wait = 0;
      if (re || we) begin
        nxt = '{addr: d_addr, wr: we, rd: re, wdata: wrt_data, fetch: 1'b0};
        q.push_back(nxt);
      end
      if (i_fetch) begin
        nxt = '{addr: i_addr, wr: 1'b0, rd: 1'b0, wdata: 16'h0, fetch: 1'b1};
        q.push_back(nxt);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", ready, m_done || (q.size() == 0 && !(i_fetch || re || we)));
      check("mem_req", mem_req, q.size() != 0);
      if (q.size() != 0) begin
        check("mem_addr", mem_addr, q[0].addr);
        check("mem_we", mem_we, q[0].wr);
        if (q[0].wr) check("mem_wdata", mem_wdata, q[0].wdata);
      end
      check("instr", instr, m_instr);
      check("rd_data", rd_data, m_rd);
      check("err", err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_fetch = 0; re = 0; we = 0; mem_ack = 0;
  endtask

  task automatic drain();
    clear_inputs();
    rst = 0;
    mem_ack = 1;
    repeat (4) tick();
    mem_ack = 0;
    tick();
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      rst       = ($urandom_range(0, 255) == 0);
      i_fetch   = ($urandom_range(0, 3) == 0);
      re        = ($urandom_range(0, 3) == 0);
      we        = ($urandom_range(0, 4) == 0);
      i_addr    = 16'($urandom);
      d_addr    = 16'($urandom);
      wrt_data  = 16'($urandom);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = 16'($urandom);
      tick();
    end
  endtask

  initial begin
    rst = 1; clear_inputs();
    i_addr = '0; d_addr = '0; wrt_data = '0; mem_rdata = '0;
    @(posedge clk);
    chk_en = 1;
    tick();
    rst = 0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_instr", instr, 0);
    check("rst_rd", rd_data, 0);
    check("rst_err", err, 0);
    check("rst_ready", ready, 1);

    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_ready", ready, 1);
      check("idle_req", mem_req, 0);
    end

    // Fetch only, acknowledged on the first access cycle.
    i_fetch = 1; i_addr = 16'h0010; #1;
    check("f_ready_n", ready, 0);
    tick();
    i_fetch = 0; i_addr = 16'hFFFF; mem_ack = 1; mem_rdata = 16'hB123; #1;
    check("f_req", mem_req, 1);
    check("f_addr", mem_addr, 16'h0010);
    check("f_ready_n1", ready, 0);
    tick();
    mem_ack = 0; mem_rdata = 16'h0; #1;
    check("f_ready_n2", ready, 1);
    check("f_instr", instr, 16'hB123);
    check("f_req_off", mem_req, 0);
    tick();
    check("f_instr_hold", instr, 16'hB123);

    // Write plus fetch: the data write goes first.
    we = 1; d_addr = 16'h0040; wrt_data = 16'h5A5A; i_fetch = 1; i_addr = 16'h0011; #1;
    check("wf_ready_n", ready, 0);
    tick();
    clear_inputs(); d_addr = 16'h1111; wrt_data = 16'h2222; i_addr = 16'h3333;
    mem_ack = 1; mem_rdata = 16'h7777; #1;
    check("wf_we", mem_we, 1);
    check("wf_addr_d", mem_addr, 16'h0040);
    check("wf_wdata", mem_wdata, 16'h5A5A);
    tick();
    mem_rdata = 16'hC0DE; #1;
    check("wf_we_i", mem_we, 0);
    check("wf_addr_i", mem_addr, 16'h0011);
    check("wf_ready_n2", ready, 0);
    tick();
    mem_ack = 0; #1;
    check("wf_ready_n3", ready, 1);
    check("wf_instr", instr, 16'hC0DE);
    check("wf_rd_hold", rd_data, 0);
    tick();

    // Read with the acknowledge delayed by three cycles.
    re = 1; d_addr = 16'h0020; tick();
    re = 0; d_addr = 16'hABCD;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3); mem_rdata = (i == 3) ? 16'h00FF : 16'hEEEE; #1;
      check("dr_req", mem_req, 1);
      check("dr_addr", mem_addr, 16'h0020);
      tick();
    end
    mem_ack = 0; #1;
    check("dr_ready", ready, 1);
    check("dr_rd", rd_data, 16'h00FF);
    tick();

    random_phase(1500);
    drain();

    // Timeout: no acknowledge for TIMEOUT cycles, then a late acknowledge.
    re = 1; d_addr = 16'h0030; tick();
    re = 0;
    for (int i = 0; i <= 255; i++) begin
      mem_ack = (i == 255); mem_rdata = 16'h1234; #1;
      if (i == 254) check("to_err_before", err, 0);
      if (i == 255) begin
        check("to_err", err, 1);
        check("to_req", mem_req, 1);
      end
      tick();
    end
    mem_ack = 0; #1;
    check("to_ready", ready, 1);
    check("to_rd", rd_data, 16'h1234);
    check("to_err_sticky", err, 1);
    tick();

    // Reset asserted in the second cycle of a data access.
    re = 1; d_addr = 16'h0050; tick();
    re = 0; tick();
    rst = 1; tick();
    rst = 0; #1;
    check("ra_req", mem_req, 0);
    check("ra_addr", mem_addr, 0);
    check("ra_rd", rd_data, 0);
    check("ra_instr", instr, 0);
    check("ra_err", err, 0);
    check("ra_ready", ready, 1);
    mem_ack = 1; mem_rdata = 16'hDEAD; tick();
    mem_ack = 0; #1;
    check("ra_late_req", mem_req, 0);
    check("ra_late_rd", rd_data, 0);
    check("ra_late_ready", ready, 1);

    random_phase(1000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, 255, max cycles mem_req may wait for mem_ack before err sets.
REQ-002 Parameter AW, 16, address width of CPU and backing ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 i_fetch  input  1  CPU instruction-fetch request.
REQ-006 i_addr  input  AW  instruction address.
REQ-007 re  input  1  CPU data read request.
REQ-008 we  input  1  CPU data write request.
REQ-009 d_addr  input  AW  data address.
REQ-010 wrt_data  input  16  data write value.
REQ-011 instr  output  16  fetched instruction, valid while ready=1.
REQ-012 rd_data  output  16  read data, valid while ready=1.
REQ-013 ready  output  1  high: all requests of this cycle complete; CPU may advance on this edge.
REQ-014 mem_req  output  1  backing-memory request, held until mem_ack.
REQ-015 mem_we  output  1  backing write qualifier, stable while mem_req=1.
REQ-016 mem_addr  output  AW  backing address, stable while mem_req=1.
REQ-017 mem_wdata  output  16  backing write data, stable while mem_req=1.
REQ-018 mem_rdata  input  16  backing read data, valid in the mem_ack cycle.
REQ-019 mem_ack  input  1  one-cycle completion pulse from backing memory.
REQ-020 err  output  1  sticky timeout flag.

Function
REQ-021 States: IDLE, D_ACC, I_ACC, DONE.
REQ-022 IDLE with i_fetch=re=we=0: ready=1 combinationally, no backing access.
REQ-023 IDLE with any request: ready=0; i_fetch, i_addr, re, we, d_addr, wrt_data captured into request registers on that edge.
REQ-024 IDLE exit: to D_ACC if re|we captured, else I_ACC.
REQ-025 Data access precedes instruction fetch; D_ACC on mem_ack goes to I_ACC if i_fetch captured, else DONE.
REQ-026 I_ACC on mem_ack goes to DONE; instr register loads mem_rdata.
REQ-027 D_ACC read: rd_data register loads mem_rdata on mem_ack.
REQ-028 re and we both set: treated as a write; rd_data loads captured wrt_data.
REQ-029 mem_req=1 throughout D_ACC and I_ACC including the mem_ack cycle; 0 in IDLE and DONE.
REQ-030 mem_we=1 only in D_ACC for a write; mem_addr = captured d_addr in D_ACC, captured i_addr in I_ACC.
REQ-031 DONE: ready=1 for exactly one cycle, then IDLE; instr and rd_data hold until next load.
REQ-032 Minimum latency: request in IDLE cycle N, single access ack at N+1 -> ready at N+2; fetch+data with ack each first cycle -> ready at N+3.
REQ-033 Wait counter 8 bits, cleared on entering D_ACC/I_ACC, increments each cycle without mem_ack, saturates at 255.
REQ-034 Counter reaching TIMEOUT sets err; state unchanged, mem_req stays asserted; err cleared only by rst.
REQ-035 mem_ack in IDLE or DONE ignored.
REQ-036 CPU inputs ignored outside IDLE; changes mid-access do not alter the access in flight.

Reset
REQ-037 rst=1 at an edge: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr=0, rd_data=0, err=0, counter=0, request registers 0.
REQ-038 rst mid-access aborts it; mem_req deasserts after that edge; an ack arriving later is ignored.
REQ-039 During rst ready follows REQ-022 on outputs after reset state.

Structure
REQ-040 Shared package mem_pkg holds the state enum, word width 16 and default TIMEOUT.
REQ-041 Single module; no sub-module.

Verification
REQ-042 Idle: i_fetch=re=we=0 -> ready=1 every cycle, mem_req=0.
REQ-043 Fetch only, i_addr=0x0010, ack next cycle, mem_rdata=0xB123 -> mem_addr=0x0010, ready one cycle at N+2, instr=0xB123.
REQ-044 Write d_addr=0x0040 wrt_data=0x5A5A plus fetch i_addr=0x0011 -> write access first (mem_we=1, addr 0x0040), then read 0x0011, ready at N+3.
REQ-045 Read 0x0020 with ack delayed 3 cycles, mem_rdata=0x00FF -> mem_req held 4 cycles, addr stable, rd_data=0x00FF.
REQ-046 No ack for 255 cycles -> err=1 at cycle 255, mem_req still 1; late ack completes access, err stays 1.
REQ-047 rst in second D_ACC cycle -> next cycle IDLE, mem_req=0, outputs 0; subsequent ack ignored.
